// File: rtl/countdown_clock.sv
// MM:SS BCD countdown driven by the one-second tick stream.
// Optional blinking low-time warning enabled by defining COUNTDOWN_WARN_EN.
module countdown_clock #(
    parameter int WARN_SECS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       expired,
    output logic       done,
    output logic       warn
);

    typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_PAUSED, S_EXPIRED} state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_mt, r_mo, r_st, r_so;
    logic [3:0] w_mt, w_mo, w_st, w_so;
    logic       r_running, r_expired, r_done, r_warn;
    logic       w_done_nxt, w_tick_acc, w_warn_nxt, w_nonzero;

    assign w_nonzero = (r_mt != 4'd0) || (r_mo != 4'd0) || (r_st != 4'd0) || (r_so != 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // One priority chain resolves load > stop > start > tick per cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_mt        = r_mt;
        w_mo        = r_mo;
        w_st        = r_st;
        w_so        = r_so;
        w_done_nxt  = 1'b0;
        w_tick_acc  = 1'b0;
        if (load) begin
            w_state_nxt = S_IDLE;
            w_mt = (load_min[7:4] > 4'd9) ? 4'd9 : load_min[7:4];
            w_mo = (load_min[3:0] > 4'd9) ? 4'd9 : load_min[3:0];
            w_st = (load_sec[7:4] > 4'd5) ? 4'd5 : load_sec[7:4];
            w_so = (load_sec[3:0] > 4'd9) ? 4'd9 : load_sec[3:0];
        end else if (stop) begin
            if (r_state == S_RUNNING) w_state_nxt = S_PAUSED;
        end else if (start) begin
            if ((r_state == S_IDLE && w_nonzero) || r_state == S_PAUSED)
                w_state_nxt = S_RUNNING;
        end else if (tick && r_state == S_RUNNING && w_nonzero) begin
            w_tick_acc = 1'b1;
            if (r_so != 4'd0) begin
                w_so = r_so - 4'd1;
            end else begin
                w_so = 4'd9;
                if (r_st != 4'd0) begin
                    w_st = r_st - 4'd1;
                end else begin
                    w_st = 4'd5;
                    if (r_mo != 4'd0) begin
                        w_mo = r_mo - 4'd1;
                    end else begin
                        w_mo = 4'd9;
                        w_mt = r_mt - 4'd1;
                    end
                end
            end
            if (r_mt == 4'd0 && r_mo == 4'd0 && r_st == 4'd0 && r_so == 4'd1) begin
                w_state_nxt = S_EXPIRED;
                w_done_nxt  = 1'b1;
            end
        end
    end

`ifdef COUNTDOWN_WARN_EN
    localparam logic [6:0] WARN_LIM = 7'(WARN_SECS);
    logic [6:0] w_secs_cur, w_secs_nxt;
    logic       w_win_cur, w_win_nxt;

    assign w_secs_cur = 7'(r_st) * 7'd10 + 7'(r_so);
    assign w_secs_nxt = 7'(w_st) * 7'd10 + 7'(w_so);
    assign w_win_cur  = (r_state == S_RUNNING || r_state == S_PAUSED) &&
                        r_mt == 4'd0 && r_mo == 4'd0 &&
                        w_secs_cur != 7'd0 && w_secs_cur <= WARN_LIM;
    assign w_win_nxt  = (w_state_nxt == S_RUNNING || w_state_nxt == S_PAUSED) &&
                        w_mt == 4'd0 && w_mo == 4'd0 &&
                        w_secs_nxt != 7'd0 && w_secs_nxt <= WARN_LIM;

    // Blink: high on window entry, then flip on every accepted tick.
    always_comb begin
        w_warn_nxt = 1'b0;
        if (load)                          w_warn_nxt = 1'b0;
        else if (w_state_nxt == S_EXPIRED) w_warn_nxt = 1'b1;
        else if (w_win_nxt && !w_win_cur)  w_warn_nxt = 1'b1;
        else if (w_win_nxt && w_tick_acc)  w_warn_nxt = ~r_warn;
        else if (w_win_nxt)                w_warn_nxt = r_warn;
    end
`else
    assign w_warn_nxt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mt      <= 4'd0;
            r_mo      <= 4'd0;
            r_st      <= 4'd0;
            r_so      <= 4'd0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_done    <= 1'b0;
            r_warn    <= 1'b0;
        end else begin
            r_mt      <= w_mt;
            r_mo      <= w_mo;
            r_st      <= w_st;
            r_so      <= w_so;
            r_running <= (w_state_nxt == S_RUNNING);
            r_expired <= (w_state_nxt == S_EXPIRED);
            r_done    <= w_done_nxt;
            r_warn    <= w_warn_nxt;
        end
    end

    assign min_tens = r_mt;
    assign min_ones = r_mo;
    assign sec_tens = r_st;
    assign sec_ones = r_so;
    assign running  = r_running;
    assign expired  = r_expired;
    assign done     = r_done;
    assign warn     = r_warn;

endmodule

// File: tb/tb_countdown_clock.sv
// Directed bench for countdown_clock (default build, warning feature off).
module tb_countdown_clock;

    logic       clk, rst, tick, load, start, stop;
    logic [7:0] load_min, load_sec;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, expired, done, warn;
    int         n_chk, n_fail;

    countdown_clock #(.WARN_SECS(10)) dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .load_min(load_min), .load_sec(load_sec), .start(start), .stop(stop),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .expired(expired), .done(done), .warn(warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] w_dig;
    logic [3:0]  w_sts;
    assign w_dig = {min_tens, min_ones, sec_tens, sec_ones};
    assign w_sts = {running, expired, done, warn};

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a falling edge: drive for one rising edge, return at the next falling edge.
    task automatic step(input logic l, input logic s, input logic p, input logic t,
                        input logic [7:0] m, input logic [7:0] sc);
        load = l; start = s; stop = p; tick = t; load_min = m; load_sec = sc;
        @(negedge clk);
        load = 0; start = 0; stop = 0; tick = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        tick = 0; load = 0; start = 0; stop = 0; load_min = 0; load_sec = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset_digits", w_dig, 16'h0000);
        chk("reset_status", {12'd0, w_sts}, 16'h0000);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 00:03 countdown to expiry
        step(1, 0, 0, 0, 8'h00, 8'h03);
        chk("load_0003", w_dig, 16'h0003);
        chk("load_idle", {12'd0, w_sts}, 16'h0000);
        step(0, 1, 0, 0, 0, 0);
        chk("start_run", {12'd0, w_sts}, 16'h0008);
        step(0, 0, 0, 1, 0, 0);
        chk("tick1", w_dig, 16'h0002);
        idle(4);
        step(0, 0, 0, 1, 0, 0);
        chk("tick2", w_dig, 16'h0001);
        idle(4);
        step(0, 0, 0, 1, 0, 0);
        chk("tick3", w_dig, 16'h0000);
        chk("expire_done", {12'd0, w_sts}, 16'h0006);
        idle(1);
        chk("done_one_cycle", {12'd0, w_sts}, 16'h0004);
        step(0, 0, 0, 1, 0, 0);
        chk("tick_in_expired", w_dig, 16'h0000);
        chk("expired_held", {12'd0, w_sts}, 16'h0004);
        step(0, 1, 0, 0, 0, 0);
        chk("start_in_expired", {12'd0, w_sts}, 16'h0004);

        // Borrow chain
        step(1, 0, 0, 0, 8'h10, 8'h00);
        chk("load_clears_exp", {12'd0, w_sts}, 16'h0000);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("borrow_1000", w_dig, 16'h0959);
        step(1, 0, 0, 0, 8'h01, 8'h00);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("borrow_0100", w_dig, 16'h0059);

        // Pause / resume
        step(1, 0, 0, 0, 8'h00, 8'h06);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("pre_pause", w_dig, 16'h0005);
        step(0, 0, 1, 0, 0, 0);
        chk("paused", {12'd0, w_sts}, 16'h0000);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        chk("paused_hold", w_dig, 16'h0005);
        step(0, 1, 0, 0, 0, 0);
        chk("resume", {12'd0, w_sts}, 16'h0008);
        step(0, 0, 0, 1, 0, 0);
        chk("resume_tick", w_dig, 16'h0004);

        // Same-cycle events
        step(1, 0, 0, 0, 8'h00, 8'h02);
        step(0, 1, 0, 1, 0, 0);
        chk("start_tick_sts", {12'd0, w_sts}, 16'h0008);
        chk("start_tick_dig", w_dig, 16'h0002);
        step(0, 0, 1, 1, 0, 0);
        chk("stop_tick_sts", {12'd0, w_sts}, 16'h0000);
        chk("stop_tick_dig", w_dig, 16'h0002);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 8'h00, 8'h07);
        chk("load_start_sts", {12'd0, w_sts}, 16'h0000);
        chk("load_start_dig", w_dig, 16'h0007);
        step(0, 0, 0, 1, 0, 0);
        chk("idle_tick", w_dig, 16'h0007);

        // Clamping
        step(1, 0, 0, 0, 8'hAF, 8'h7C);
        chk("clamp_max", w_dig, 16'h9959);
        step(1, 0, 0, 0, 8'h5A, 8'h39);
        chk("clamp_min_ones", w_dig, 16'h5939);

        // Zero load, start ignored
        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 0, 0, 0);
        chk("zero_start", {12'd0, w_sts}, 16'h0000);
        step(0, 0, 0, 1, 0, 0);
        chk("zero_no_done", {12'd0, w_sts}, 16'h0000);

        // Back-to-back ticks, then async reset at 00:01 with a tick pending
        step(1, 0, 0, 0, 8'h00, 8'h03);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("b2b_ticks", w_dig, 16'h0001);
        tick = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_dig", w_dig, 16'h0000);
        chk("async_rst_sts", {12'd0, w_sts}, 16'h0000);
        @(posedge clk); #1;
        chk("async_rst_nodone", {12'd0, w_sts}, 16'h0000);
        @(negedge clk);
        tick = 1'b0;
        rst = 1'b1;
        idle(2);
        chk("post_rst_dig", w_dig, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
